dot3_mul_sequencer: RTL and testbench

DOT3_MUL_SEQUENCER -- requirements
Module: dot3_mul_sequencer

---
 rtl/dot3_mul_sequencer_if.sv | 30 +++
 rtl/dot3_mul_sequencer.sv | 104 ++++++++++
 tb/tb_dot3_mul_sequencer.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/dot3_mul_sequencer_if.sv
// Handshake bundle between a dot3_mul_sequencer, its requester and its downstream multiplier.
// The sequencer connects through the slave modport; the environment uses the master modport.
interface dot3_mul_sequencer_if #(parameter int WIDTH = 32);
  logic             iInputReady;
  logic [WIDTH-1:0] iAx, iAy, iAz;
  logic [WIDTH-1:0] iBx, iBy, iBz;
  logic             iUnscaled;
  logic [WIDTH-1:0] oMulA, oMulB;
  logic             oMulInputReady;
  logic             oMulUnscaled;
  logic [WIDTH-1:0] iMulResult;
  logic             iMulOutputReady;
  logic [WIDTH-1:0] oR;
  logic             oOutputReady;
  logic             oBusy;

  modport slave (
    input  iInputReady, iAx, iAy, iAz, iBx, iBy, iBz, iUnscaled,
    input  iMulResult, iMulOutputReady,
    output oMulA, oMulB, oMulInputReady, oMulUnscaled,
    output oR, oOutputReady, oBusy
  );

  modport master (
    output iInputReady, iAx, iAy, iAz, iBx, iBy, iBz, iUnscaled,
    output iMulResult, iMulOutputReady,
    input  oMulA, oMulB, oMulInputReady, oMulUnscaled,
    input  oR, oOutputReady, oBusy
  );
endinterface

// File: rtl/dot3_mul_sequencer.sv
// Computes A.B for two 3-element vectors by issuing one product at a time to an
// external multiplier and accumulating the returned products with wrap-around.
module dot3_mul_sequencer #(
  parameter int WIDTH = 32
) (
  input logic                  clk,
  input logic                  rst,
  dot3_mul_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t           state_q;
  logic [1:0]       idx_q;
  logic [WIDTH-1:0] ay_q, az_q, by_q, bz_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] mulA_q, mulB_q;
  logic [WIDTH-1:0] r_q;
  logic             issue_q;
  logic             unscaled_q;
  logic             outReady_q;
  logic             busy_q;
  logic [WIDTH-1:0] accSum_d;

  assign accSum_d = acc_q + bus.iMulResult;

  // The x pair is loaded straight into the operand registers at start, so only y/z are kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= 2'd0;
      ay_q       <= '0;
      az_q       <= '0;
      by_q       <= '0;
      bz_q       <= '0;
      acc_q      <= '0;
      mulA_q     <= '0;
      mulB_q     <= '0;
      r_q        <= '0;
      issue_q    <= 1'b0;
      unscaled_q <= 1'b0;
      outReady_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      issue_q    <= 1'b0;
      outReady_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.iInputReady) begin
            ay_q       <= bus.iAy;
            az_q       <= bus.iAz;
            by_q       <= bus.iBy;
            bz_q       <= bus.iBz;
            unscaled_q <= bus.iUnscaled;
            acc_q      <= '0;
            idx_q      <= 2'd0;
            mulA_q     <= bus.iAx;
            mulB_q     <= bus.iBx;
            issue_q    <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          state_q <= WAIT;
        end
        // Result-valid pulses are only honoured here; stray pulses elsewhere fall through.
        WAIT: begin
          if (bus.iMulOutputReady) begin
            acc_q <= accSum_d;
            if (idx_q == 2'd2) begin
              r_q        <= accSum_d;
              outReady_q <= 1'b1;
              state_q    <= DONE;
            end else begin
              idx_q   <= idx_q + 2'd1;
              mulA_q  <= (idx_q == 2'd0) ? ay_q : az_q;
              mulB_q  <= (idx_q == 2'd0) ? by_q : bz_q;
              issue_q <= 1'b1;
              state_q <= ISSUE;
            end
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.oMulA          = mulA_q;
  assign bus.oMulB          = mulB_q;
  assign bus.oMulInputReady = issue_q;
  assign bus.oMulUnscaled   = unscaled_q;
  assign bus.oR             = r_q;
  assign bus.oOutputReady   = outReady_q;
  assign bus.oBusy          = busy_q;

endmodule

// File: tb/tb_dot3_mul_sequencer.sv
// Directed bench for dot3_mul_sequencer with a behavioural 2-cycle multiplier
// that can stretch one product's latency and keeps running across resets.
module tb_dot3_mul_sequencer;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dot3_mul_sequencer_if #(.WIDTH(W)) bus ();

  dot3_mul_sequencer #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic         mulValid  = 1'b0;
  logic [W-1:0] mulResult = '0;
  logic [W-1:0] prod      = '0;
  int           cnt         = 0;
  int           modelIssues = 0;
  int           stallBase   = 0;
  int           stallExtra  = 0;

  assign bus.iMulOutputReady = mulValid;
  assign bus.iMulResult      = mulResult;

  // Issue latched at edge n gives a one-cycle valid pulse after edge n+1 (+stallExtra for the second product).
  always @(posedge clk) begin
    mulValid <= 1'b0;
    if (cnt == 1) begin
      mulValid  <= 1'b1;
      mulResult <= prod;
    end
    if (cnt != 0) cnt <= cnt - 1;
    if (bus.oMulInputReady) begin
      prod        <= bus.oMulA * bus.oMulB;
      cnt         <= ((modelIssues - stallBase) == 1) ? 1 + stallExtra : 1;
      modelIssues <= modelIssues + 1;
    end
  end

  task automatic runJob(
    input  logic [W-1:0] ax, ay, az, bx, by, bz,
    input  bit           busyPoke,
    input  int           extra,
    input  bit           stopAtDone,
    input  logic [W-1:0] prevR,
    output int           doneCycle,
    output logic [W-1:0] result,
    output int           issues,
    output int           issueMask,
    output int           doneCount,
    output int           busyErrs,
    output int           unscaledErrs,
    output int           holdErrs
  );
    @(negedge clk);
    bus.iAx = ax; bus.iAy = ay; bus.iAz = az;
    bus.iBx = bx; bus.iBy = by; bus.iBz = bz;
    bus.iUnscaled   = 1'b1;
    bus.iInputReady = 1'b1;
    stallBase  = modelIssues;
    stallExtra = extra;
    @(posedge clk);
    #1 bus.iInputReady = 1'b0;
    doneCycle = -1; result = '0; issues = 0; issueMask = 0;
    doneCount = 0; busyErrs = 0; unscaledErrs = 0; holdErrs = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      bus.iInputReady = busyPoke && (k == 2 || k == 8);
      if (bus.oMulInputReady === 1'b1) begin
        issues++;
        issueMask = issueMask | (1 << k);
      end
      if (bus.oOutputReady === 1'b1) begin
        doneCount++;
        if (doneCycle < 0) begin
          doneCycle = k;
          result    = bus.oR;
        end
      end
      if ((doneCycle < 0 || k == doneCycle) && bus.oBusy !== 1'b1) busyErrs++;
      if (doneCycle >= 0 && k > doneCycle && bus.oBusy !== 1'b0) busyErrs++;
      if (doneCycle < 0 && bus.oMulUnscaled !== 1'b1) unscaledErrs++;
      if (doneCycle < 0 && bus.oR !== prevR) holdErrs++;
      if (stopAtDone && doneCycle >= 0) break;
    end
    bus.iInputReady = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.iInputReady = 1'b0; bus.iUnscaled = 1'b0;
    bus.iAx = '0; bus.iAy = '0; bus.iAz = '0;
    bus.iBx = '0; bus.iBy = '0; bus.iBz = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.oMulA, bus.oMulB, bus.oR} !== {3*W{1'b0}}) begin
      errors++;
      $display("[TB] FAIL reset_data: got A=%h B=%h R=%h, expected all 0", bus.oMulA, bus.oMulB, bus.oR);
    end
    checks++;
    if ({bus.oMulInputReady, bus.oMulUnscaled, bus.oOutputReady, bus.oBusy} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b, expected 0000",
               {bus.oMulInputReady, bus.oMulUnscaled, bus.oOutputReady, bus.oBusy});
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int dc, is, im, dn, be, ue, he;
    logic [W-1:0] r;
    runJob(1, 2, 3, 4, 5, 6, 1'b0, 0, 1'b0, '0, dc, r, is, im, dn, be, ue, he);
    checks++; if (r !== 32'h00000020) begin errors++; $display("[TB] FAIL basic_result: got %h expected 00000020", r); end
    checks++; if (dc !== 10) begin errors++; $display("[TB] FAIL basic_latency: got %0d expected 10", dc); end
    checks++; if (is !== 3) begin errors++; $display("[TB] FAIL basic_issue_count: got %0d expected 3", is); end
    checks++; if (im !== 32'h92) begin errors++; $display("[TB] FAIL basic_issue_cycles: got mask %h expected 92", im); end
    checks++; if (dn !== 1) begin errors++; $display("[TB] FAIL basic_done_count: got %0d expected 1", dn); end
    checks++; if (be !== 0) begin errors++; $display("[TB] FAIL basic_busy: got %0d bad cycles expected 0", be); end
    checks++; if (ue !== 0) begin errors++; $display("[TB] FAIL basic_unscaled: got %0d bad cycles expected 0", ue); end
  endtask

  task automatic test_negative();
    int dc, is, im, dn, be, ue, he;
    logic [W-1:0] r;
    runJob(32'hFFFFFFFF, 2, 32'hFFFFFFFD, 4, 5, 6, 1'b0, 0, 1'b0, 32'h20, dc, r, is, im, dn, be, ue, he);
    checks++; if (r !== 32'hFFFFFFF4) begin errors++; $display("[TB] FAIL neg_result: got %h expected fffffff4", r); end
    checks++; if (he !== 0) begin errors++; $display("[TB] FAIL neg_or_hold: got %0d changes expected 0", he); end
  endtask

  task automatic test_wrap();
    int dc, is, im, dn, be, ue, he;
    logic [W-1:0] r;
    runJob(32'h7FFFFFFF, 1, 0, 1, 1, 0, 1'b0, 0, 1'b0, 32'hFFFFFFF4, dc, r, is, im, dn, be, ue, he);
    checks++; if (r !== 32'h80000000) begin errors++; $display("[TB] FAIL wrap_result: got %h expected 80000000", r); end
  endtask

  task automatic test_busy_reject();
    int dc, is, im, dn, be, ue, he;
    logic [W-1:0] r;
    runJob(1, 2, 3, 4, 5, 6, 1'b1, 0, 1'b0, 32'h80000000, dc, r, is, im, dn, be, ue, he);
    checks++; if (r !== 32'h20) begin errors++; $display("[TB] FAIL busy_result: got %h expected 00000020", r); end
    checks++; if (dn !== 1) begin errors++; $display("[TB] FAIL busy_done_count: got %0d expected 1", dn); end
    checks++; if (is !== 3) begin errors++; $display("[TB] FAIL busy_issue_count: got %0d expected 3", is); end
    checks++; if (be !== 0) begin errors++; $display("[TB] FAIL busy_flag: got %0d bad cycles expected 0", be); end
    checks++; if (dc !== 10) begin errors++; $display("[TB] FAIL busy_latency: got %0d expected 10", dc); end
  endtask

  task automatic test_stall();
    int dc, is, im, dn, be, ue, he;
    logic [W-1:0] r;
    runJob(2, 3, 4, 5, 6, 7, 1'b0, 5, 1'b0, 32'h20, dc, r, is, im, dn, be, ue, he);
    checks++; if (r !== 32'd56) begin errors++; $display("[TB] FAIL stall_result: got %h expected 00000038", r); end
    checks++; if (dc !== 15) begin errors++; $display("[TB] FAIL stall_latency: got %0d expected 15", dc); end
    checks++; if (he !== 0) begin errors++; $display("[TB] FAIL stall_or_hold: got %0d changes expected 0", he); end
    checks++; if (be !== 0) begin errors++; $display("[TB] FAIL stall_busy: got %0d bad cycles expected 0", be); end
    stallExtra = 0;
  endtask

  task automatic test_mid_reset();
    int dc, is, im, dn, be, ue, he;
    int lateDone, lateBad;
    logic [W-1:0] r;
    @(negedge clk);
    bus.iAx = 1; bus.iAy = 2; bus.iAz = 3;
    bus.iBx = 4; bus.iBy = 5; bus.iBz = 6;
    bus.iUnscaled = 1'b1; bus.iInputReady = 1'b1;
    stallBase = modelIssues;
    @(posedge clk);
    #1 bus.iInputReady = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.oMulA, bus.oMulB, bus.oR, bus.oMulInputReady, bus.oMulUnscaled, bus.oOutputReady, bus.oBusy}
        !== {3*W+4{1'b0}}) begin
      errors++;
      $display("[TB] FAIL midreset_async: got A=%h B=%h R=%h flags=%b expected all 0", bus.oMulA, bus.oMulB,
               bus.oR, {bus.oMulInputReady, bus.oMulUnscaled, bus.oOutputReady, bus.oBusy});
    end
    #2 rst = 1'b0;
    lateDone = 0; lateBad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.oOutputReady !== 1'b0) lateDone++;
      if (bus.oBusy !== 1'b0 || bus.oR !== '0 || bus.oMulInputReady !== 1'b0) lateBad++;
    end
    checks++; if (lateDone !== 0) begin errors++; $display("[TB] FAIL midreset_no_done: got %0d pulses expected 0", lateDone); end
    checks++; if (lateBad !== 0) begin errors++; $display("[TB] FAIL midreset_idle: got %0d bad cycles expected 0", lateBad); end
    runJob(1, 1, 1, 1, 1, 1, 1'b0, 0, 1'b0, '0, dc, r, is, im, dn, be, ue, he);
    checks++; if (r !== 32'd3) begin errors++; $display("[TB] FAIL midreset_next_result: got %h expected 00000003", r); end
    checks++; if (dc !== 10) begin errors++; $display("[TB] FAIL midreset_next_latency: got %0d expected 10", dc); end
  endtask

  task automatic test_back_to_back();
    int dc, is, im, dn, be, ue, he;
    logic [W-1:0] r;
    runJob(1, 2, 3, 1, 1, 1, 1'b0, 0, 1'b1, 32'd3, dc, r, is, im, dn, be, ue, he);
    checks++; if (r !== 32'd6) begin errors++; $display("[TB] FAIL b2b_first_result: got %h expected 00000006", r); end
    runJob(2, 0, 0, 3, 0, 0, 1'b0, 0, 1'b0, 32'd6, dc, r, is, im, dn, be, ue, he);
    checks++; if (dc !== 10) begin errors++; $display("[TB] FAIL b2b_second_latency: got %0d expected 10", dc); end
    checks++; if (r !== 32'd6 || dn !== 1) begin errors++; $display("[TB] FAIL b2b_second_result: got %h/%0d expected 00000006/1", r, dn); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_wrap();
    test_busy_reject();
    test_stall();
    test_mid_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
